// File: rtl/ps2_seq_pkg.sv
// ps2_seq_pkg (rev 1.0): opcodes, scan-code constants, prefix FSM encoding
// and the make-code decoder shared by the PS/2 key sequencer.
`default_nettype none

package ps2_seq_pkg;

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_DIGIT  = 3'd1;
  localparam logic [2:0] OP_ENTER  = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_CANCEL = 3'd4;
  localparam logic [2:0] OP_NEXT   = 3'd5;
  localparam logic [2:0] OP_PREV   = 3'd6;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_DIGIT0 = 8'h45;
  localparam logic [7:0] SC_DIGIT1 = 8'h16;
  localparam logic [7:0] SC_DIGIT2 = 8'h1E;
  localparam logic [7:0] SC_DIGIT3 = 8'h26;
  localparam logic [7:0] SC_DIGIT4 = 8'h25;
  localparam logic [7:0] SC_DIGIT5 = 8'h2E;
  localparam logic [7:0] SC_DIGIT6 = 8'h36;
  localparam logic [7:0] SC_DIGIT7 = 8'h3D;
  localparam logic [7:0] SC_DIGIT8 = 8'h3E;
  localparam logic [7:0] SC_DIGIT9 = 8'h46;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_CLEAR  = 8'h66;
  localparam logic [7:0] SC_CANCEL = 8'h76;
  localparam logic [7:0] SC_NEXT   = 8'h75;
  localparam logic [7:0] SC_PREV   = 8'h72;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] arg;
  } cmd_t;

  // Unrecognised makes decode to OP_NONE with a zero argument.
  function automatic cmd_t decode_make(input logic ext, input logic [7:0] code);
    cmd_t c;
    c.op  = OP_NONE;
    c.arg = 4'd0;
    if (!ext) begin
      case (code)
        SC_DIGIT0: begin c.op = OP_DIGIT; c.arg = 4'd0; end
        SC_DIGIT1: begin c.op = OP_DIGIT; c.arg = 4'd1; end
        SC_DIGIT2: begin c.op = OP_DIGIT; c.arg = 4'd2; end
        SC_DIGIT3: begin c.op = OP_DIGIT; c.arg = 4'd3; end
        SC_DIGIT4: begin c.op = OP_DIGIT; c.arg = 4'd4; end
        SC_DIGIT5: begin c.op = OP_DIGIT; c.arg = 4'd5; end
        SC_DIGIT6: begin c.op = OP_DIGIT; c.arg = 4'd6; end
        SC_DIGIT7: begin c.op = OP_DIGIT; c.arg = 4'd7; end
        SC_DIGIT8: begin c.op = OP_DIGIT; c.arg = 4'd8; end
        SC_DIGIT9: begin c.op = OP_DIGIT; c.arg = 4'd9; end
        SC_ENTER:  c.op = OP_ENTER;
        SC_CLEAR:  c.op = OP_CLEAR;
        SC_CANCEL: c.op = OP_CANCEL;
        default:   c.op = OP_NONE;
      endcase
    end else begin
      case (code)
        SC_ENTER: c.op = OP_ENTER;
        SC_NEXT:  c.op = OP_NEXT;
        SC_PREV:  c.op = OP_PREV;
        default:  c.op = OP_NONE;
      endcase
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_cmd_fifo.sv
// ps2_cmd_fifo (rev 1.0): show-ahead command FIFO with level and full/empty flags.
`default_nettype none

module ps2_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is still taken when a pop frees the slot this edge.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer (rev 1.0): PS/2 prefix FSM, make-code decode and command FIFO.
// Define KEY_REPEAT_FILTER_EN to drop typematic repeats of the currently held key.
`default_nettype none

module ps2_key_sequencer
  import ps2_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          BYTE_VALID,
  input  logic [7:0]                    BYTE_DATA,
  input  logic                          BYTE_ERR,
  input  logic                          CMD_READY,
  output logic                          CMD_VALID,
  output logic [2:0]                    CMD_OP,
  output logic [3:0]                    CMD_ARG,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERFLOW,
  output logic [7:0]                    ERR_CNT
);

  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          make_ev;
  logic          make_ext;
  logic          brk_ev;
  logic          brk_ext;
  cmd_t          make_cmd;
  logic          is_repeat;
  logic          push_nxt;
  logic          push_q;
  cmd_t          push_cmd;
  logic          held_valid;
  logic [8:0]    held_key;
  logic [6:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    make_ev   = 1'b0;
    make_ext  = 1'b0;
    brk_ev    = 1'b0;
    brk_ext   = 1'b0;
    if (BYTE_VALID) begin
      if (BYTE_ERR) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (BYTE_DATA == SC_EXT)      state_nxt = ST_EXT;
            else if (BYTE_DATA == SC_BRK) state_nxt = ST_BRK;
            else                          make_ev   = 1'b1;
          end
          ST_EXT: begin
            if (BYTE_DATA == SC_BRK)      state_nxt = ST_EXT_BRK;
            else if (BYTE_DATA == SC_EXT) state_nxt = ST_EXT;
            else begin
              make_ev   = 1'b1;
              make_ext  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          ST_BRK: begin
            brk_ev    = 1'b1;
            state_nxt = ST_IDLE;
          end
          default: begin
            brk_ev    = 1'b1;
            brk_ext   = 1'b1;
            state_nxt = ST_IDLE;
          end
        endcase
      end
    end else if (state != ST_IDLE && tmo_cnt == TMO_LAST) begin
      state_nxt = ST_IDLE;
    end
  end

  assign make_cmd = decode_make(make_ext, BYTE_DATA);

`ifdef KEY_REPEAT_FILTER_EN
  assign is_repeat = held_valid && (held_key == {make_ext, BYTE_DATA});
`else
  assign is_repeat = 1'b0;
`endif

  assign push_nxt = make_ev && (make_cmd.op != OP_NONE) && !is_repeat;
  assign pop      = CMD_READY && !fifo_empty;

  // Decode is registered so the FIFO write lands one cycle after the strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt    <= '0;
      push_q     <= 1'b0;
      push_cmd   <= '0;
      held_valid <= 1'b0;
      held_key   <= '0;
      OVERFLOW   <= 1'b0;
      ERR_CNT    <= 8'd0;
    end else begin
      if (BYTE_VALID || state == ST_IDLE) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + 1'b1;

      push_q   <= push_nxt;
      push_cmd <= make_cmd;

      if (BYTE_VALID && BYTE_ERR) begin
        held_valid <= 1'b0;
        held_key   <= '0;
      end else if (make_ev && make_cmd.op != OP_NONE) begin
        held_valid <= 1'b1;
        held_key   <= {make_ext, BYTE_DATA};
      end else if (brk_ev && held_valid && held_key == {brk_ext, BYTE_DATA}) begin
        held_valid <= 1'b0;
        held_key   <= '0;
      end

      if (push_q && fifo_full && !pop) OVERFLOW <= 1'b1;

      if (BYTE_VALID && BYTE_ERR && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

  ps2_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (7)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (push_q),
    .wr_data (push_cmd),
    .rd_en   (CMD_READY),
    .rd_data (head),
    .level   (FIFO_LEVEL),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign CMD_VALID         = !fifo_empty;
  assign {CMD_OP, CMD_ARG} = fifo_empty ? 7'd0 : head;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: directed and randomized byte streams against a queue-based reference model.
`default_nettype none

module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic       byte_err = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] err_cnt;

  ps2_key_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .BYTE_VALID (byte_valid),
    .BYTE_DATA  (byte_data),
    .BYTE_ERR   (byte_err),
    .CMD_READY  (cmd_ready),
    .CMD_VALID  (cmd_valid),
    .CMD_OP     (cmd_op),
    .CMD_ARG    (cmd_arg),
    .FIFO_LEVEL (fifo_level),
    .OVERFLOW   (overflow),
    .ERR_CNT    (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: expected FIFO contents plus the keyboard-protocol context.
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];
  int         cyc = 0;
  logic       m_pend = 1'b0;
  logic [6:0] m_pcmd = 7'd0;
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  int         m_last = 0;
  logic       m_held_v = 1'b0;
  logic [8:0] m_held = 9'd0;
  logic       m_ovf = 1'b0;
  int         m_err = 0;
  logic       s_valid = 1'b0;
  logic [2:0] s_op = 3'd0;
  logic [3:0] s_arg = 4'd0;
  logic       mon_en = 1'b0;
  logic       rand_ready = 1'b0;
  int         vld_cnt = 0;
  int         first_vld = -1;
  int         strobe_cyc = 0;

  function automatic logic [6:0] ref_decode(input logic ext, input logic [7:0] b);
    logic [7:0] digits [10];
    digits = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 10; i++)
      if (!ext && b == digits[i]) return {3'd1, 4'(i)};
    if (b == 8'h5A)         return {3'd2, 4'd0};
    if (!ext && b == 8'h66) return {3'd3, 4'd0};
    if (!ext && b == 8'h76) return {3'd4, 4'd0};
    if (ext && b == 8'h75)  return {3'd5, 4'd0};
    if (ext && b == 8'h72)  return {3'd6, 4'd0};
    return 7'd0;
  endfunction

  task automatic model_byte();
    logic [6:0] c;
    logic [8:0] key;
    logic       filt;
    if (byte_err) begin
      m_ext = 0; m_brk = 0; m_held_v = 0;
      if (m_err < 255) m_err++;
    end else begin
      if ((m_ext || m_brk) && (cyc - m_last) > TMO) begin
        m_ext = 0; m_brk = 0;
      end
      key = {m_ext, byte_data};
      if (m_brk) begin
        if (m_held_v && m_held == key) m_held_v = 0;
        m_ext = 0; m_brk = 0;
      end else if (byte_data == 8'hE0) begin
        m_ext = 1;
      end else if (byte_data == 8'hF0) begin
        m_brk = 1;
      end else begin
        c = ref_decode(m_ext, byte_data);
        if (c[6:4] != 3'd0) begin
`ifdef KEY_REPEAT_FILTER_EN
          filt = m_held_v && m_held == key;
`else
          filt = 1'b0;
`endif
          if (!filt) begin
            m_pend = 1; m_pcmd = c;
          end
          m_held_v = 1; m_held = key;
        end
        m_ext = 0;
      end
    end
    m_last = cyc;
  endtask

  task automatic model_step();
    logic pop;
    if (!rst_n) begin
      exp_q.delete();
      m_pend = 0; m_ext = 0; m_brk = 0; m_held_v = 0; m_ovf = 0; m_err = 0;
      return;
    end
    cyc++;
    if (s_valid && cmd_ready) obs_q.push_back({s_op, s_arg});
    pop = (exp_q.size() != 0) && cmd_ready;
    if (m_pend && !pop && exp_q.size() >= DEPTH) m_ovf = 1;
    if (pop) void'(exp_q.pop_front());
    if (m_pend && exp_q.size() < DEPTH) exp_q.push_back(m_pcmd);
    m_pend = 0;
    if (byte_valid) model_byte();
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic monitor_step();
    logic [6:0] hd;
    s_valid = cmd_valid; s_op = cmd_op; s_arg = cmd_arg;
    if (!mon_en) return;
    hd = (exp_q.size() != 0) ? exp_q[0] : 7'd0;
    check_eq("cmd_valid", 32'(cmd_valid), 32'(exp_q.size() != 0));
    check_eq("cmd_head", {25'd0, cmd_op, cmd_arg}, {25'd0, hd});
    check_eq("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("err_cnt", 32'(err_cnt), 32'(m_err));
    if (cmd_valid) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc;
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic drive_ready();
    if (rand_ready) cmd_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e, input int spacing);
    @(negedge clk);
    byte_valid = 1'b1; byte_data = b; byte_err = e; strobe_cyc = cyc;
    drive_ready();
    for (int i = 1; i < spacing; i++) begin
      @(negedge clk);
      byte_valid = 1'b0; byte_err = 1'b0;
      drive_ready();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0; byte_err = 1'b0;
      drive_ready();
    end
  endtask

  // want holds entry i at bits [7*i +: 7]
  task automatic check_obs(input string tag, input int n, input logic [27:0] want);
    check_eq({tag, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_pop%0d", tag, i),
               (i < obs_q.size()) ? 32'(obs_q[i]) : 32'h7F, 32'(want[7*i +: 7]));
  endtask

  logic [7:0] pool [15];
  logic [7:0] rb;

  initial begin
    pool = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
             8'h3E, 8'h46, 8'h5A, 8'h66, 8'h76, 8'h75, 8'h72};
    repeat (3) @(negedge clk);
    check_eq("reset_valid", 32'(cmd_valid), 0);
    check_eq("reset_head", {25'd0, cmd_op, cmd_arg}, 0);
    check_eq("reset_level", 32'(fifo_level), 0);
    check_eq("reset_ovf", 32'(overflow), 0);
    check_eq("reset_err", 32'(err_cnt), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(3);

    // Single digit make then its break
    obs_q.delete(); vld_cnt = 0; first_vld = -1;
    send_byte(8'h16, 0, 4);
    check_eq("t1_strobe", 32'(strobe_cyc >= 0), 1);
    begin
      int sc;
      sc = strobe_cyc;
      send_byte(8'hF0, 0, 4);
      send_byte(8'h16, 0, 4);
      idle(6);
      check_eq("t1_latency", first_vld - sc, 2);
    end
    check_eq("t1_valid_cycles", vld_cnt, 1);
    check_obs("t1", 1, {21'd0, 3'd1, 4'd1});

    // Extended navigation keys and an extended break
    obs_q.delete();
    send_byte(8'hE0, 0, 3); send_byte(8'h75, 0, 3);
    send_byte(8'hE0, 0, 3); send_byte(8'hF0, 0, 3); send_byte(8'h75, 0, 3);
    send_byte(8'hE0, 0, 3); send_byte(8'h72, 0, 3);
    idle(6);
    check_obs("t2", 2, {14'd0, 3'd6, 4'd0, 3'd5, 4'd0});

    // Typematic repeats of digit 0
    obs_q.delete();
    repeat (3) send_byte(8'h45, 0, 3);
    send_byte(8'hF0, 0, 3); send_byte(8'h45, 0, 3);
    send_byte(8'h45, 0, 3);
    idle(6);
`ifdef KEY_REPEAT_FILTER_EN
    check_obs("t3", 2, {14'd0, 7'h10, 7'h10});
`else
    check_obs("t3", 4, {7'h10, 7'h10, 7'h10, 7'h10});
`endif

    // Fill past capacity with the allocator stalled
    obs_q.delete();
    cmd_ready = 1'b0;
    send_byte(8'h16, 0, 3); send_byte(8'h1E, 0, 3); send_byte(8'h26, 0, 3);
    send_byte(8'h25, 0, 3); send_byte(8'h2E, 0, 3); send_byte(8'h36, 0, 3);
    idle(4);
    check_eq("t4_level", 32'(fifo_level), 4);
    check_eq("t4_ovf", 32'(overflow), 1);
    cmd_ready = 1'b1;
    idle(8);
    check_obs("t4", 4, {7'h14, 7'h13, 7'h12, 7'h11});

    // Prefix timeout and error bytes
    obs_q.delete();
    send_byte(8'hE0, 0, TMO + 3); send_byte(8'h5A, 0, 3);
    send_byte(8'hE0, 0, TMO + 3); send_byte(8'h75, 0, 3);
    send_byte(8'hE0, 0, TMO - 3); send_byte(8'h75, 0, 3);
    send_byte(8'hE0, 0, 3); send_byte(8'h33, 1, 3); send_byte(8'h75, 0, 3);
    idle(6);
    check_obs("t5", 2, {14'd0, 3'd5, 4'd0, 3'd2, 4'd0});
    check_eq("t5_err_cnt", 32'(err_cnt), 1);

    // Asynchronous reset mid-sequence
    obs_q.delete();
    cmd_ready = 1'b0;
    send_byte(8'h3D, 0, 3); send_byte(8'h3E, 0, 3); send_byte(8'h46, 0, 3);
    send_byte(8'hE0, 0, 2); send_byte(8'hF0, 0, 2);
    check_eq("t6_level_pre", 32'(fifo_level), 3);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(cmd_valid), 0);
    check_eq("t6_rst_head", {25'd0, cmd_op, cmd_arg}, 0);
    check_eq("t6_rst_level", 32'(fifo_level), 0);
    check_eq("t6_rst_ovf", 32'(overflow), 0);
    check_eq("t6_rst_err", 32'(err_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    send_byte(8'h66, 0, 3);
    idle(6);
    check_obs("t6", 1, {21'd0, 3'd3, 4'd0});

    // Randomized byte stream with random back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int sel;
      int sp;
      sel = $urandom_range(0, 99);
      if (sel < 25)      rb = 8'hE0;
      else if (sel < 40) rb = 8'hF0;
      else if (sel < 80) rb = pool[$urandom_range(0, 14)];
      else               rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) sp = TMO - 3 + $urandom_range(0, 6);
      else                           sp = $urandom_range(2, 6);
      send_byte(rb, ($urandom_range(0, 24) == 0), sp);
    end
    rand_ready = 1'b0;
    cmd_ready = 1'b1;
    idle(20);
    check_eq("rand_drained", 32'(fifo_level), 0);

    // Error counter saturation
    repeat (260) send_byte(8'h00, 1, 2);
    idle(3);
    check_eq("err_saturate", 32'(err_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Sequences the raw PS/2 byte stream from the keyboard receiver into debounced operator commands for the parking-spot allocator. Runs a prefix FSM over 0xE0 (extended) and 0xF0 (break) bytes, maps recognised make codes to command opcodes, optionally suppresses typematic repeats, and buffers commands in a small FIFO with a valid/ready handshake. It sits between the PS/2 receiver and the allocator's operator-input port.

## Interface
Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- TIMEOUT_CYC, 500000: CLK cycles a prefix state may wait for its next byte before abandoning the sequence.

Ports:
- CLK  in  1  board clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- BYTE_VALID  in  1  one-cycle strobe: a received byte is on BYTE_DATA/BYTE_ERR.
- BYTE_DATA  in  8  received scan-code byte.
- BYTE_ERR  in  1  framing/parity error flag for the strobed byte.
- CMD_READY  in  1  allocator accepts the head command.
- CMD_VALID  out  1  FIFO non-empty; head command presented.
- CMD_OP  out  3  head opcode.
- CMD_ARG  out  4  head argument (digit value; 0 for other opcodes).
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  entries held.
- OVERFLOW  out  1  sticky: a command was dropped because the FIFO was full.
- ERR_CNT  out  8  saturating count of bytes received with BYTE_ERR.

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
- IDLE: E0→EXT; F0→BRK; other byte = make code (non-extended) → decode →IDLE.
- EXT: F0→EXT_BRK; E0→EXT (stay); other = extended make → decode →IDLE.
- BRK / EXT_BRK: any byte = break code of {ext,code} → release handling →IDLE.
- Byte with BYTE_ERR=1: discarded, FSM→IDLE, held-key register cleared, ERR_CNT+1 saturating at 255.
- Prefix timeout: counter reset on each BYTE_VALID; in any non-IDLE state, reaching TIMEOUT_CYC →IDLE, no command.
- Decode (make codes): 0x45,16,1E,26,25,2E,36,3D,3E,46 → OP_DIGIT, arg 0–9; 0x5A (ext or not) → OP_ENTER; 0x66 → OP_CLEAR; 0x76 → OP_CANCEL; E0 75 → OP_NEXT; E0 72 → OP_PREV. All other makes ignored. Opcodes: NONE=0, DIGIT=1, ENTER=2, CLEAR=3, CANCEL=4, NEXT=5, PREV=6.
- Recognised make pushes {op,arg} into FIFO and records {ext,code} as held key.
- Break of held key clears held key; break of any other key has no effect.
- FIFO: show-ahead; pop on CMD_VALID && CMD_READY. Push when full without simultaneous pop → command dropped, OVERFLOW set (cleared only by reset). Push and pop together when full → both accepted, level unchanged. Pop when empty ignored.

## Timing
- Reset values: CMD_VALID=0, CMD_OP=0, CMD_ARG=0, FIFO_LEVEL=0, OVERFLOW=0, ERR_CNT=0; FSM=IDLE, held key cleared, timeout counter 0.
- Decode registered: BYTE_VALID in cycle N → FIFO write at edge ending N+1 → CMD_VALID=1 in cycle N+2 (FIFO previously empty).
- Pop at edge ending cycle M; next head (or CMD_VALID=0) visible in M+1.
- BYTE_VALID at most once per 2 cycles guaranteed by the receiver; back-to-back strobes need not be handled.
- Reset mid-sequence: FSM, FIFO contents and flags lost immediately (asynchronous).

## Configuration
- KEY_REPEAT_FILTER_EN defined: a recognised make whose {ext,code} equals the held key is dropped (typematic suppression), no push, no OVERFLOW.
- Undefined: held-key comparison removed; every recognised make, including repeats, is pushed.

## Structure
- Package ps2_seq_pkg: opcode constants, scan-code constants (E0, F0, digit table, 5A, 66, 76, 75, 72), FSM state encoding.
- One sub-module: ps2_cmd_fifo (parameterised DEPTH, width 7, show-ahead, level and full/empty outputs); sequencer instantiates it.

## Test plan
- Bytes 0x16, F0 16 with CMD_READY=1 → one command OP=1 ARG=1, CMD_VALID high exactly one cycle, 2 cycles after first strobe.
- E0 75, E0 F0 75, E0 72 → commands NEXT(5) then PREV(6); no command from break sequence.
- 0x45 sent 3× then F0 45, 0x45: with KEY_REPEAT_FILTER_EN → DIGIT 0 twice total; without → four DIGIT 0.
- CMD_READY=0, six distinct recognised makes with FIFO_DEPTH=4 → FIFO_LEVEL=4, OVERFLOW=1, drain yields first four in order.
- Byte 0xE0 then silence TIMEOUT_CYC cycles, then 0x5A → single ENTER (non-ext path), FSM back to IDLE; byte with BYTE_ERR=1 → ERR_CNT=1, no command.
- RST_N low while FIFO holds 3 entries and FSM in EXT_BRK → all outputs at reset values same cycle; next 0x66 → CLEAR.
